regfile_bist: RTL and testbench
===============================

Name: regfile_bist

Overview:
Self-checking access sequencer that drives the write/read side of the 32x32 CPU register file (regfile) for power-on and board-level checks. On start it writes every register with seed+address through the write port. It then reads all 32 registers back, two per cycle on both read ports, and compares each against the expected value. It reports done/pass, an error count and the first failing address; it sits beside the CPU and is muxed onto the regfile ports when the CPU is held.

Parameters:
ZERO_REG_HARDWIRED, 1, 1: register 0 is expected to read 0 regardless of writes; 0: register 0 is expected to read seed+0.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  begin a test run; sampled only in IDLE
seed  input  32  base data pattern, latched when start is accepted
busy  output  1  high while in WRITE or READ
done  output  1  one-cycle pulse when a run completes
pass  output  1  run result: 1 = no mismatches; valid from the done pulse until the next accepted start
err_count  output  6  number of mismatching reads in the run (0..32)
fail_valid  output  1  at least one mismatch recorded
fail_addr  output  5  register address of the first mismatch
rf_we  output  1  regfile write enable
rf_waddr  output  5  regfile write address
rf_wdata  output  32  regfile write data
rf_raddr1  output  5  regfile read address, port 1
rf_raddr2  output  5  regfile read address, port 2
rf_rdata1  input  32  regfile read data, port 1; combinational from rf_raddr1
rf_rdata2  input  32  regfile read data, port 2; combinational from rf_raddr2

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous) forces all outputs to 0 immediately and the FSM to IDLE. Reset mid-run aborts the run; regfile contents are left as written.
- FSM states: IDLE, WRITE, READ, DONE. A 5-bit counter cnt and a 32-bit seed register are held internally.
- IDLE, start=1 at edge E0:
  - latch seed; cnt=0; clear err_count, fail_valid, fail_addr, pass.
  - go to WRITE.
  - start in any other state is ignored.
- WRITE, cycles E0..E31:
  - rf_we=1, rf_waddr=cnt, rf_wdata=seed+cnt (32-bit add, wraps modulo 2^32).
  - cnt increments each edge; writes commit at edges E1..E32.
  - After the cnt=31 cycle, go to READ with cnt=0 and rf_we=0.
- READ, 16 cycles, addresses driven during E32..E47:
  - rf_raddr1=cnt, rf_raddr2=cnt+16 (cnt 0..15).
  - At each following edge (E33..E48), compare rf_rdata1 and rf_rdata2 against their expected values.
- Expected value for address a: 0 if a==0 and ZERO_REG_HARDWIRED=1, otherwise seed+a.
- Error recording per compare edge:
  - err_count increments by 0, 1 or 2.
  - If fail_valid was 0, set fail_valid=1 and set fail_addr to the failing address. If both ports fail in the same cycle, record the port-1 (lower) address.
  - Later mismatches never overwrite fail_addr.
- After the cnt=15 compare, go to DONE.
- DONE:
  - done=1 for exactly one cycle (E48..E49); pass=(err_count==0), including the final compare.
  - Then IDLE.
  - pass, err_count, fail_valid and fail_addr hold until the next accepted start or reset.
- Run length: the done pulse occurs 48 cycles after the start edge.
- busy is 1 from E0 to E48 and 0 in DONE and IDLE.
- In IDLE and DONE: rf_we=0 and the address and data outputs are 0.

Test Plan:
1. Reset: hold rst=0 with start=1 -> all outputs 0; release rst with start=0 -> FSM stays IDLE, busy=0.
2. Good regfile model, ZERO_REG_HARDWIRED=1, seed=0x00FF00FF, start for one cycle:
   - rf_waddr steps 0..31 with rf_wdata 0x00FF00FF..0x00FF011E.
   - Read pairs (0,16)..(15,31).
   - done pulses 48 cycles after start; pass=1, err_count=0, fail_valid=0.
3. Model with bit 0 of reg 6 stuck at 0 (reg 6 reads 0x00FF0104 instead of 0x00FF0105), seed=0x00FF00FF -> pass=0, err_count=1, fail_valid=1, fail_addr=6.
4. Model with regs 3 and 19 each XORed with 0x1 -> both mismatch in the same cycle; err_count=2, fail_addr=3.
5. Model where reg 0 stores writes, ZERO_REG_HARDWIRED=1, seed=0xFFFFFFF0:
   - reg 0 reads 0xFFFFFFF0 -> fail_addr=0, err_count=1.
   - Repeat with ZERO_REG_HARDWIRED=0 -> pass=1; reg 31 expected 0x0000000F (wrap).
6. Reset and start-while-busy:
   - Pulse start again while busy -> ignored; run length is unchanged.
   - Assert rst=0 at write cycle 10 -> rf_we drops at once, busy=0, done never pulses.
   - After release, start with seed=0x00FF00FF -> completes with pass=1.

Source files
------------

// File: rtl/regfile_bist.sv
// Power-on / board-level self test for the 32x32 register file: writes seed+addr
// to every register, reads them back two per cycle and reports pass, error count and first failure.
module regfile_bist #(
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic        fail_valid,
  output logic [4:0]  fail_addr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt, cnt_nx;
  logic [31:0] seed_r, seed_nx;

  logic        busy_nx, done_nx, pass_nx, fv_nx, we_nx;
  logic [5:0]  err_nx;
  logic [4:0]  fa_nx, waddr_nx, ra1_nx, ra2_nx;
  logic [31:0] wdata_nx;

  logic [4:0]  cnt_inc;
  logic [4:0]  addr_hi;
  logic        mis1, mis2;

  function automatic logic [31:0] expval(input logic [31:0] s, input logic [4:0] a);
    if (ZERO_REG_HARDWIRED && a == 5'd0)
      expval = 32'd0;
    else
      expval = s + {27'd0, a};
  endfunction

  // During READ cnt stays in 0..15, so port 2 always addresses the upper half.
  assign cnt_inc = cnt + 5'd1;
  assign addr_hi = {1'b1, cnt[3:0]};
  assign mis1    = (rf_rdata1 != expval(seed_r, cnt));
  assign mis2    = (rf_rdata2 != expval(seed_r, addr_hi));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      seed_r     <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 6'd0;
      fail_valid <= 1'b0;
      fail_addr  <= 5'd0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'd0;
      rf_raddr1  <= 5'd0;
      rf_raddr2  <= 5'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      seed_r     <= seed_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      pass       <= pass_nx;
      err_count  <= err_nx;
      fail_valid <= fv_nx;
      fail_addr  <= fa_nx;
      rf_we      <= we_nx;
      rf_waddr   <= waddr_nx;
      rf_wdata   <= wdata_nx;
      rf_raddr1  <= ra1_nx;
      rf_raddr2  <= ra2_nx;
    end
  end

  // Every output is computed one cycle ahead so that all ports come straight from flops.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    seed_nx  = seed_r;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    pass_nx  = pass;
    err_nx   = err_count;
    fv_nx    = fail_valid;
    fa_nx    = fail_addr;
    we_nx    = 1'b0;
    waddr_nx = 5'd0;
    wdata_nx = 32'd0;
    ra1_nx   = 5'd0;
    ra2_nx   = 5'd0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nx = WRITE;
          seed_nx  = seed;
          cnt_nx   = 5'd0;
          pass_nx  = 1'b0;
          err_nx   = 6'd0;
          fv_nx    = 1'b0;
          fa_nx    = 5'd0;
          busy_nx  = 1'b1;
          we_nx    = 1'b1;
          waddr_nx = 5'd0;
          wdata_nx = seed;
        end
      end

      WRITE: begin
        busy_nx = 1'b1;
        if (cnt == 5'd31) begin
          state_nx = READ;
          cnt_nx   = 5'd0;
          ra1_nx   = 5'd0;
          ra2_nx   = 5'd16;
        end else begin
          cnt_nx   = cnt_inc;
          we_nx    = 1'b1;
          waddr_nx = cnt_inc;
          wdata_nx = seed_r + {27'd0, cnt_inc};
        end
      end

      READ: begin
        err_nx = err_count + {5'd0, mis1} + {5'd0, mis2};
        // Only the first failure is kept; port 1 wins a same-cycle tie.
        if (!fail_valid && (mis1 || mis2)) begin
          fv_nx = 1'b1;
          fa_nx = mis1 ? cnt : addr_hi;
        end
        if (cnt == 5'd15) begin
          state_nx = DONE;
          done_nx  = 1'b1;
          pass_nx  = (err_nx == 6'd0);
        end else begin
          busy_nx = 1'b1;
          cnt_nx  = cnt_inc;
          ra1_nx  = cnt_inc;
          ra2_nx  = cnt + 5'd17;
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Bench for regfile_bist: two instances (zero register hardwired / not) share stimulus,
// each drives its own faulty-capable regfile model and is compared against a timeline model.
module tb_regfile_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed_in = 32'd0;

  logic        busy[2], done[2], pass[2], fail_valid[2], rf_we[2];
  logic [5:0]  err_count[2];
  logic [4:0]  fail_addr[2], rf_waddr[2], rf_raddr1[2], rf_raddr2[2];
  logic [31:0] rf_wdata[2], rf_rdata1[2], rf_rdata2[2];

  logic [31:0] mem0[32];
  logic [31:0] mem1[32];
  logic        rf_zero = 1'b1;
  logic [31:0] and_mask[32];
  logic [31:0] xor_mask[32];

  int errors = 0;
  int checks = 0;
  int run_len = 0;
  int done_cnt = 0;
  logic [31:0] last_w31 = 32'd0;

  always #5 clk = ~clk;

  regfile_bist #(.ZERO_REG_HARDWIRED(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .seed(seed_in),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .fail_valid(fail_valid[0]), .fail_addr(fail_addr[0]),
    .rf_we(rf_we[0]), .rf_waddr(rf_waddr[0]), .rf_wdata(rf_wdata[0]),
    .rf_raddr1(rf_raddr1[0]), .rf_raddr2(rf_raddr2[0]),
    .rf_rdata1(rf_rdata1[0]), .rf_rdata2(rf_rdata2[0])
  );

  regfile_bist #(.ZERO_REG_HARDWIRED(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .seed(seed_in),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .fail_valid(fail_valid[1]), .fail_addr(fail_addr[1]),
    .rf_we(rf_we[1]), .rf_waddr(rf_waddr[1]), .rf_wdata(rf_wdata[1]),
    .rf_raddr1(rf_raddr1[1]), .rf_raddr2(rf_raddr2[1]),
    .rf_rdata1(rf_rdata1[1]), .rf_rdata2(rf_rdata2[1])
  );

  // Regfile model with optional reg-0 hardwiring and per-address stuck/flip faults.
  function automatic logic [31:0] rd_val(input logic [31:0] v, input logic [4:0] a,
                                         input logic z, input logic [31:0] am,
                                         input logic [31:0] xm);
    rd_val = (((z && a == 5'd0) ? 32'd0 : v) & am) ^ xm;
  endfunction

  always @(posedge clk) begin
    if (rf_we[0]) mem0[rf_waddr[0]] <= rf_wdata[0];
    if (rf_we[1]) mem1[rf_waddr[1]] <= rf_wdata[1];
  end

  always_comb begin
    rf_rdata1[0] = rd_val(mem0[rf_raddr1[0]], rf_raddr1[0], rf_zero, and_mask[rf_raddr1[0]], xor_mask[rf_raddr1[0]]);
    rf_rdata2[0] = rd_val(mem0[rf_raddr2[0]], rf_raddr2[0], rf_zero, and_mask[rf_raddr2[0]], xor_mask[rf_raddr2[0]]);
    rf_rdata1[1] = rd_val(mem1[rf_raddr1[1]], rf_raddr1[1], rf_zero, and_mask[rf_raddr1[1]], xor_mask[rf_raddr1[1]]);
    rf_rdata2[1] = rd_val(mem1[rf_raddr2[1]], rf_raddr2[1], rf_zero, and_mask[rf_raddr2[1]], xor_mask[rf_raddr2[1]]);
  end

  // Reference: t = cycles since the accepted start edge (-1 when idle).
  int          t = -1;
  logic [31:0] m_seed = 32'd0;
  int          m_err[2] = '{0, 0};
  logic        m_fv[2] = '{1'b0, 1'b0};
  logic [4:0]  m_fa[2] = '{5'd0, 5'd0};
  logic        m_pass[2] = '{1'b0, 1'b0};

  function automatic logic [31:0] golden(input logic hw, input int a);
    golden = (hw && a == 0) ? 32'd0 : m_seed + 32'(a);
  endfunction

  function automatic logic mism(input logic hw, input int a);
    logic [31:0] stored;
    stored = rd_val(m_seed + 32'(a), 5'(a), rf_zero, and_mask[a], xor_mask[a]);
    mism = (stored != golden(hw, a));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t <= -1;
      for (int d = 0; d < 2; d++) begin
        m_err[d] <= 0; m_fv[d] <= 1'b0; m_fa[d] <= 5'd0; m_pass[d] <= 1'b0;
      end
    end else if (t == -1) begin
      if (start) begin
        t <= 0;
        m_seed <= seed_in;
        for (int d = 0; d < 2; d++) begin
          m_err[d] <= 0; m_fv[d] <= 1'b0; m_fa[d] <= 5'd0; m_pass[d] <= 1'b0;
        end
      end
    end else if (t == 48) begin
      t <= -1;
    end else begin
      t <= t + 1;
      // Pair (t-32, t-16) is judged at this edge.
      if (t >= 32) begin
        for (int d = 0; d < 2; d++) begin
          m_err[d] <= m_err[d] + int'(mism(1'(d), t - 32)) + int'(mism(1'(d), t - 16));
          if (!m_fv[d] && (mism(1'(d), t - 32) || mism(1'(d), t - 16))) begin
            m_fv[d] <= 1'b1;
            m_fa[d] <= mism(1'(d), t - 32) ? 5'(t - 32) : 5'(t - 16);
          end
          if (t == 47)
            m_pass[d] <= ((m_err[d] + int'(mism(1'(d), t - 32)) + int'(mism(1'(d), t - 16))) == 0);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d.busy", d), 32'(busy[d]), 32'(t >= 0 && t <= 47));
      checkOutput($sformatf("dut%0d.done", d), 32'(done[d]), 32'(t == 48));
      checkOutput($sformatf("dut%0d.rf_we", d), 32'(rf_we[d]), 32'(t >= 0 && t <= 31));
      checkOutput($sformatf("dut%0d.rf_waddr", d), 32'(rf_waddr[d]), (t >= 0 && t <= 31) ? 32'(t) : 32'd0);
      checkOutput($sformatf("dut%0d.rf_wdata", d), rf_wdata[d], (t >= 0 && t <= 31) ? m_seed + 32'(t) : 32'd0);
      checkOutput($sformatf("dut%0d.rf_raddr1", d), 32'(rf_raddr1[d]), (t >= 32 && t <= 47) ? 32'(t - 32) : 32'd0);
      checkOutput($sformatf("dut%0d.rf_raddr2", d), 32'(rf_raddr2[d]), (t >= 32 && t <= 47) ? 32'(t - 16) : 32'd0);
      checkOutput($sformatf("dut%0d.err_count", d), 32'(err_count[d]), 32'(m_err[d]));
      checkOutput($sformatf("dut%0d.fail_valid", d), 32'(fail_valid[d]), 32'(m_fv[d]));
      checkOutput($sformatf("dut%0d.fail_addr", d), 32'(fail_addr[d]), 32'(m_fa[d]));
      checkOutput($sformatf("dut%0d.pass", d), 32'(pass[d]), 32'(m_pass[d]));
    end
  end

  always @(negedge clk) begin
    if (rf_we[1] && rf_waddr[1] == 5'd31) last_w31 <= rf_wdata[1];
    if (done[1]) done_cnt <= done_cnt + 1;
  end

  task automatic clearFaults();
    for (int i = 0; i < 32; i++) begin
      and_mask[i] = 32'hFFFF_FFFF;
      xor_mask[i] = 32'd0;
    end
  endtask

  // One run: start for one cycle, optionally re-pulse start mid-run, wait (bounded) for done.
  task automatic applyStimulus(input logic [31:0] s, input bit repulse);
    int n;
    @(negedge clk);
    #1 start = 1'b1;
    seed_in = s;
    @(negedge clk);
    #1 start = 1'b0;
    seed_in = ~s;
    n = 0;
    while (!done[1] && n < 100) begin
      @(negedge clk);
      n++;
      if (repulse && n == 10) #1 start = 1'b1;
      if (repulse && n == 11) #1 start = 1'b0;
    end
    run_len = n;
    checkOutput("run length", 32'(n), 32'd48);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    clearFaults();

    #2 rst = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset busy", 32'(busy[1]), 32'd0);
    checkOutput("reset rf_we", 32'(rf_we[1]), 32'd0);
    checkOutput("reset done", 32'(done[1]), 32'd0);
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle busy", 32'(busy[1]), 32'd0);
    checkOutput("idle rf_we", 32'(rf_we[1]), 32'd0);

    rf_zero = 1'b1;
    applyStimulus(32'h00FF_00FF, 1'b0);
    checkOutput("good pass", 32'(pass[1]), 32'd1);
    checkOutput("good err_count", 32'(err_count[1]), 32'd0);
    checkOutput("good fail_valid", 32'(fail_valid[1]), 32'd0);
    checkOutput("good last wdata", last_w31, 32'h00FF_011E);

    and_mask[6] = 32'hFFFF_FFFE;
    applyStimulus(32'h00FF_00FF, 1'b0);
    checkOutput("stuck pass", 32'(pass[1]), 32'd0);
    checkOutput("stuck err_count", 32'(err_count[1]), 32'd1);
    checkOutput("stuck fail_valid", 32'(fail_valid[1]), 32'd1);
    checkOutput("stuck fail_addr", 32'(fail_addr[1]), 32'd6);
    clearFaults();

    xor_mask[3] = 32'd1;
    xor_mask[19] = 32'd1;
    applyStimulus(32'h00FF_00FF, 1'b0);
    checkOutput("pair err_count", 32'(err_count[1]), 32'd2);
    checkOutput("pair fail_addr", 32'(fail_addr[1]), 32'd3);
    clearFaults();

    rf_zero = 1'b0;
    applyStimulus(32'hFFFF_FFF0, 1'b0);
    checkOutput("reg0 hw fail_addr", 32'(fail_addr[1]), 32'd0);
    checkOutput("reg0 hw err_count", 32'(err_count[1]), 32'd1);
    checkOutput("reg0 soft pass", 32'(pass[0]), 32'd1);
    checkOutput("reg0 soft err_count", 32'(err_count[0]), 32'd0);
    checkOutput("wrap last wdata", last_w31, 32'h0000_000F);
    rf_zero = 1'b1;

    applyStimulus(32'h00FF_00FF, 1'b1);
    checkOutput("repulse pass", 32'(pass[1]), 32'd1);

    @(negedge clk);
    #1 start = 1'b1;
    seed_in = 32'h1234_5678;
    @(negedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("abort rf_we", 32'(rf_we[1]), 32'd0);
    checkOutput("abort busy", 32'(busy[1]), 32'd0);
    d0 = done_cnt;
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (60) @(negedge clk);
    checkOutput("abort no done", 32'(done_cnt), 32'(d0));
    applyStimulus(32'h00FF_00FF, 1'b0);
    checkOutput("after abort pass", 32'(pass[1]), 32'd1);

    for (int r = 0; r < 6; r++) begin
      clearFaults();
      rf_zero = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2))
        xor_mask[$urandom_range(0, 31)] ^= (32'd1 << $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0)
        and_mask[$urandom_range(0, 31)] = ~(32'd1 << $urandom_range(0, 31));
      applyStimulus($urandom, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
